// File: rtl/dram_sdp_pipe.sv
// Simple-dual-port block memory with byte-enable writes, a fixed-latency read pipeline,
// selectable read-during-write result and an optional zero-clear sweep after reset.
module dram_sdp_pipe #(
    parameter int DATA_WIDTH     = 512,
    parameter int DEPTH          = 1024,
    parameter int ADDR_WIDTH     = $clog2(DEPTH),
    parameter int READ_LATENCY   = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1,
    localparam int BE_WIDTH      = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [BE_WIDTH-1:0]   wr_be,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  init_done
);

    typedef enum logic [1:0] {S_RESET, S_CLEAR, S_READY} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    wr_in_range, rd_in_range;
    logic                    wr_ok, rd_ok, clr_we;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_wa;
    logic [BE_WIDTH-1:0]     mem_wbe;
    logic [DATA_WIDTH-1:0]   mem_wd;
    logic [DATA_WIDTH-1:0]   rd_word;

    logic [READ_LATENCY-1:0] vld_pipe;
    logic [DATA_WIDTH-1:0]   dat_pipe [READ_LATENCY];

    // A power-of-two depth has no unreachable addresses, so skip the compare entirely.
    if ((2 ** ADDR_WIDTH) == DEPTH) begin : g_full_range
        assign wr_in_range = 1'b1;
        assign rd_in_range = 1'b1;
    end else begin : g_part_range
        assign wr_in_range = {1'b0, wr_addr} < (ADDR_WIDTH + 1)'(DEPTH);
        assign rd_in_range = {1'b0, rd_addr} < (ADDR_WIDTH + 1)'(DEPTH);
    end

    assign clr_we = !rst && (state == S_CLEAR);
    assign wr_ok  = !rst && (state == S_READY) && wr_en && wr_in_range;
    assign rd_ok  = !rst && (state == S_READY) && rd_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RESET;
            clr_cnt   <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                S_RESET: begin
                    clr_cnt <= '0;
                    if (CLEAR_ON_RESET != 0) begin
                        state <= S_CLEAR;
                    end else begin
                        state     <= S_READY;
                        init_done <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                        state     <= S_READY;
                        init_done <= 1'b1;
                    end
                end
                S_READY: init_done <= 1'b1;
                default: state <= S_RESET;
            endcase
        end
    end

    // Clear sweep and user writes share the single write port.
    always_comb begin
        mem_we  = 1'b0;
        mem_wa  = wr_addr;
        mem_wbe = wr_be;
        mem_wd  = wr_data;
        if (clr_we) begin
            mem_we  = 1'b1;
            mem_wa  = clr_cnt;
            mem_wbe = '1;
            mem_wd  = '0;
        end else if (wr_ok) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (mem_wbe[i]) mem[mem_wa][8*i +: 8] <= mem_wd[8*i +: 8];
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[rd_addr];
            if ((RDW_MODE != 0) && wr_ok && (wr_addr == rd_addr)) begin
                for (int i = 0; i < BE_WIDTH; i++) begin
                    if (wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
                end
            end
        end
    end

    // Each stage only loads when its incoming valid is set, so the last stage holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int k = 0; k < READ_LATENCY; k++) dat_pipe[k] <= '0;
        end else begin
            vld_pipe[0] <= rd_ok;
            if (rd_ok) dat_pipe[0] <= rd_word;
            for (int k = 1; k < READ_LATENCY; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                if (vld_pipe[k-1]) dat_pipe[k] <= dat_pipe[k-1];
            end
        end
    end

    assign rd_valid = vld_pipe[READ_LATENCY-1];
    assign rd_data  = dat_pipe[READ_LATENCY-1];

endmodule
